lcd_bus_responder: RTL and testbench
====================================

Name: lcd_bus_responder

Overview:
HD44780-compatible responder that sits on the far side of the 8-bit LCD bus (en, rs, rw, D) and emulates the controller the panel driver writes to. It decodes instructions, maintains a 2x40 DDRAM, an address counter, display-control flags and a busy flag, and answers status and data reads. A registered character readout port lets the VGA text overlay, or a scoreboard, see the 2x16 visible window.

Parameters:
BUSY_CYCLES, 8, clock cycles busy is held after any accepted non-clear write.
CLEAR_CHAR, 8'h20, fill value used by the clear-display instruction.

Ports:
clock  in  1  system clock; faster than lcd_en by at least 4x.
reset_n  in  1  asynchronous active-low reset.
lcd_en  in  1  bus enable; asynchronous to clock; transfer latched on its falling edge.
lcd_rs  in  1  0 = instruction/status, 1 = data.
lcd_rw  in  1  0 = write, 1 = read.
lcd_d  in  8  write data bus.
lcd_d_out  out  8  read data.
lcd_d_oe  out  1  read-drive enable.
rd_row  in  1  readout row.
rd_col  in  4  readout column 0..15.
rd_char  out  8  character at (rd_row, rd_col); 1-cycle latency.
display_on, cursor_on, blink_on  out  1 each  display-control flags.
two_line  out  1  N bit of the last function set.
busy  out  1  busy flag.
ac  out  7  address counter.
overrun  out  1  sticky: a write arrived while busy.

Behaviour:
- Reset values: all flags, ac, overrun, busy, lcd_d_out and lcd_d_oe = 0; rd_char = 0; the increment flag I/D = 1; state = IDLE. DDRAM is not cleared by reset.
- Bus capture:
  - lcd_en passes through a 2-FF synchroniser, then falling-edge detect.
  - rs, rw and d are captured with the same 2-FF depth, so they stay aligned with the edge.
  - One transfer is handled per falling edge.
- DDRAM index = ac[6] ? 40 + ac[5:0] : ac[5:0].
  - Writes with ac[5:0] > 39 are discarded.
  - ac still advances on such writes.
- ac advance: I/D = 1 gives +1, with 0x27 -> 0x40 and 0x67 -> 0x00. I/D = 0 gives -1, with 0x40 -> 0x27 and 0x00 -> 0x67.
- Write decode (rw = 0). For rs = 0, the highest set bit of d selects the instruction:
  - 0x01 clear: enter CLEAR; ac = 0; I/D = 1.
  - 0x02/0x03 return home: ac = 0.
  - 0000_01 I/D S: entry mode.
  - 0000_1DCB: set display_on, cursor_on, blink_on.
  - 0001_S/C R/L x x:
    - S/C = 0 moves ac by one toward R/L, using the wrap rules above.
    - S/C = 1 is the display shift.
  - 001_DL N F xx: sets two_line from N; DL and F are ignored.
  - 01xx_xxxx CGRAM address: accepted, no storage. Following data writes are discarded until a DDRAM address is set.
  - 1AAA_AAAA: ac = d[6:0].
- Data write (rw = 0, rs = 1): write d at the current DDRAM index, then advance ac.
- Reads:
  - Status read (rw = 1, rs = 0): lcd_d_oe is high while the synchronised en is high; lcd_d_out = {busy, ac}. Serviced even while busy.
  - Data read (rw = 1, rs = 1): lcd_d_out = DDRAM[index]; ac advances on the falling edge.
- FSM states: IDLE, EXEC, CLEAR.
  - IDLE -> EXEC on any accepted write; busy = 1; counter loaded with BUSY_CYCLES - 1; return to IDLE at 0.
  - CLEAR writes CLEAR_CHAR to indices 0..79, one per cycle; busy = 1 for 80 cycles, then IDLE.
- Write while busy: dropped, no state change, overrun = 1 (cleared only by reset).
- Reset during CLEAR: abort immediately; DDRAM is left partially filled.
- Readout: rd_char is registered from DDRAM[row*40 + ((col + shift) mod 40)].
  - shift is 0 unless the optional feature is compiled in.
  - rd_char = CLEAR_CHAR when display_on = 0.
- Same-cycle readout and bus write: the write wins; the readout returns the new value next cycle.

Optional Feature:
LCD_DISPLAY_SHIFT_EN
- With the macro: a 6-bit shift register, 0..39 mod 40, is kept.
  - S/C = 1 instructions move it right or left by one.
  - Entry-mode S = 1 shifts it on every data write, in the direction set by I/D.
  - Clear and return home zero it.
- Without the macro: S/C = 1 and S are accepted, but shift stays at constant 0.

Decomposition:
- Package lcd_pkg:
  - state enum {IDLE, EXEC, CLEAR};
  - instruction masks and opcodes;
  - LINE1_BASE = 7'h00, LINE2_BASE = 7'h40, LINE_LEN = 40, VIS_COLS = 16;
  - function ac_next(ac, inc).
- Sub-module lcd_en_sync: 2-FF synchroniser and falling-edge pulse for en/rs/rw/d.

Test Plan:
1. Reset, then write 0x38, 0x0E, 0x01, 0x06 -> two_line = 1, display_on = 1, cursor_on = 1, blink_on = 0; busy high for 80 cycles after 0x01; all 32 rd_char = 0x20.
2. Write 0x80, then data "NS:0" -> row 0 cols 0..3 = 0x4E, 0x53, 0x3A, 0x30; ac = 0x04.
3. Write 0xC0, then 16 data bytes 0x41..0x50 -> row 1 matches; ac = 0x50; write 0x80 -> ac = 0x00.
4. Write 0xA7 plus one data byte -> ac = 0x40. Write 0xE7 plus one data byte -> ac = 0x00. Then 0x04 plus one data byte at ac 0x00 -> ac = 0x67.
5. Write a data byte 2 en-edges after 0x0C with BUSY_CYCLES = 200 -> byte dropped, DDRAM unchanged, overrun = 1.
6. Status read during CLEAR -> lcd_d_out = 0x80, lcd_d_oe high only while en high. Then assert reset_n = 0 mid-CLEAR -> busy = 0 and state = IDLE immediately.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types, instruction decode and address-counter helpers for the HD44780-style responder.
// Optional display-shift support is enabled in the top module with `define LCD_DISPLAY_SHIFT_EN.
package lcd_pkg;

  typedef enum logic [1:0] {IDLE, EXEC, CLEAR} lcd_state_e;

  typedef enum logic [3:0] {
    INS_NONE, INS_CLEAR, INS_HOME, INS_ENTRY, INS_DISPLAY,
    INS_SHIFT, INS_FUNC, INS_CGRAM, INS_DDRAM
  } lcd_instr_e;

  localparam logic [6:0] LINE1_BASE = 7'h00;
  localparam logic [6:0] LINE2_BASE = 7'h40;
  localparam int         LINE_LEN   = 40;
  localparam int         VIS_COLS   = 16;
  localparam int         DDRAM_SIZE = 2 * LINE_LEN;

  // Field positions inside the instruction byte
  localparam int ENTRY_ID = 1;
  localparam int SHIFT_SC = 3;
  localparam int SHIFT_RL = 2;
  localparam int FUNC_N   = 3;

  // The highest set bit of the instruction byte selects the command.
  function automatic lcd_instr_e decode_instr(input logic [7:0] d);
    lcd_instr_e r;
    casez (d)
      8'b1???_????: r = INS_DDRAM;
      8'b01??_????: r = INS_CGRAM;
      8'b001?_????: r = INS_FUNC;
      8'b0001_????: r = INS_SHIFT;
      8'b0000_1???: r = INS_DISPLAY;
      8'b0000_01??: r = INS_ENTRY;
      8'b0000_001?: r = INS_HOME;
      8'b0000_0001: r = INS_CLEAR;
      default:      r = INS_NONE;
    endcase
    return r;
  endfunction

  function automatic logic [6:0] ac_next(input logic [6:0] ac, input logic inc);
    logic [6:0] r;
    if (inc) begin
      if (ac == LINE1_BASE + 7'(LINE_LEN - 1))      r = LINE2_BASE;
      else if (ac == LINE2_BASE + 7'(LINE_LEN - 1)) r = LINE1_BASE;
      else                                          r = ac + 7'd1;
    end else begin
      if (ac == LINE2_BASE)      r = LINE1_BASE + 7'(LINE_LEN - 1);
      else if (ac == LINE1_BASE) r = LINE2_BASE + 7'(LINE_LEN - 1);
      else                       r = ac - 7'd1;
    end
    return r;
  endfunction

  function automatic logic [6:0] ddram_index(input logic [6:0] ac);
    return ac[6] ? 7'(LINE_LEN) + {1'b0, ac[5:0]} : {1'b0, ac[5:0]};
  endfunction

  function automatic logic ddram_valid(input logic [6:0] ac);
    return ac[5:0] < 6'(LINE_LEN);
  endfunction

  function automatic logic [5:0] shift_step(input logic [5:0] s, input logic right);
    logic [5:0] r;
    if (right) r = (s == 6'(LINE_LEN - 1)) ? 6'd0 : s + 6'd1;
    else       r = (s == 6'd0) ? 6'(LINE_LEN - 1) : s - 6'd1;
    return r;
  endfunction

endpackage

// File: rtl/lcd_en_sync.sv
// Brings the asynchronous LCD bus into the clock domain: two flops on every bus line,
// plus a falling-edge pulse on the synchronised enable that marks one transfer.
module lcd_en_sync (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       lcd_en,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_d,
  output logic       en_s,
  output logic       fall,
  output logic       rs_s,
  output logic       rw_s,
  output logic [7:0] d_s
);

  logic       en_p0, en_p1, en_p2;
  logic       rs_p0, rs_p1;
  logic       rw_p0, rw_p1;
  logic [7:0] d_p0, d_p1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      en_p0 <= 1'b0;
      en_p1 <= 1'b0;
      en_p2 <= 1'b0;
    end else begin
      en_p0 <= lcd_en;
      en_p1 <= en_p0;
      en_p2 <= en_p1;
    end
  end

  // Same depth as the enable so the captured fields line up with the edge pulse
  always_ff @(posedge clock) begin
    rs_p0 <= lcd_rs;
    rs_p1 <= rs_p0;
    rw_p0 <= lcd_rw;
    rw_p1 <= rw_p0;
    d_p0  <= lcd_d;
    d_p1  <= d_p0;
  end

  assign en_s = en_p1;
  assign fall = en_p2 & ~en_p1;
  assign rs_s = rs_p1;
  assign rw_s = rw_p1;
  assign d_s  = d_p1;

endmodule

// File: rtl/lcd_bus_responder.sv
// HD44780-compatible bus responder: instruction decode, 2x40 DDRAM, busy/clear sequencing
// and a registered 2x16 readout. `define LCD_DISPLAY_SHIFT_EN adds the display-shift register.
module lcd_bus_responder
  import lcd_pkg::*;
#(
  parameter int         BUSY_CYCLES = 8,
  parameter logic [7:0] CLEAR_CHAR  = 8'h20
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         lcd_en,
  input  logic                         lcd_rs,
  input  logic                         lcd_rw,
  input  logic [7:0]                   lcd_d,
  output logic [7:0]                   lcd_d_out,
  output logic                         lcd_d_oe,
  input  logic                         rd_row,
  input  logic [$clog2(VIS_COLS)-1:0]  rd_col,
  output logic [7:0]                   rd_char,
  output logic                         display_on,
  output logic                         cursor_on,
  output logic                         blink_on,
  output logic                         two_line,
  output logic                         busy,
  output logic [6:0]                   ac,
  output logic                         overrun
);

  localparam int               CNT_W      = 16;
  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(DDRAM_SIZE - 1);

  logic       en_s, fall, rs_s, rw_s;
  logic [7:0] d_s;

  lcd_en_sync u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .lcd_en  (lcd_en),
    .lcd_rs  (lcd_rs),
    .lcd_rw  (lcd_rw),
    .lcd_d   (lcd_d),
    .en_s    (en_s),
    .fall    (fall),
    .rs_s    (rs_s),
    .rw_s    (rw_s),
    .d_s     (d_s)
  );

  lcd_state_e       state, state_nxt;
  lcd_instr_e       instr;
  logic [CNT_W-1:0] cnt;
  logic             inc_id, cgram_mode;
  logic [5:0]       shift;
  logic             wr_acc, wr_drop, rd_fall, clr_we;
  logic [7:0]       ddram [DDRAM_SIZE];
  logic             mem_we;
  logic [6:0]       mem_waddr;
  logic [7:0]       mem_wdata;
  logic [7:0]       bus_rd_data;
  logic [6:0]       col_sum, col_mod, rd_idx;

  assign instr   = decode_instr(d_s);
  assign wr_acc  = fall & ~rw_s & (state == IDLE);
  assign wr_drop = fall & ~rw_s & (state != IDLE);
  assign rd_fall = fall & rw_s & rs_s;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (wr_acc) state_nxt = (!rs_s && instr == INS_CLEAR) ? CLEAR : EXEC;
      EXEC:    if (cnt == '0) state_nxt = IDLE;
      CLEAR:   if (cnt == CLEAR_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != IDLE);
    clr_we = (state == CLEAR);
  end

  // EXEC counts down to zero; CLEAR counts up and doubles as the fill address
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (state == IDLE) begin
      if (wr_acc) cnt <= (!rs_s && instr == INS_CLEAR) ? '0 : CNT_W'(BUSY_CYCLES - 1);
    end else if (state == EXEC) begin
      cnt <= cnt - 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ac         <= '0;
      inc_id     <= 1'b1;
      cgram_mode <= 1'b0;
      display_on <= 1'b0;
      cursor_on  <= 1'b0;
      blink_on   <= 1'b0;
      two_line   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (wr_drop) overrun <= 1'b1;
      if (wr_acc && rs_s) begin
        if (!cgram_mode) ac <= ac_next(ac, inc_id);
      end else if (wr_acc) begin
        case (instr)
          INS_CLEAR: begin
            ac         <= LINE1_BASE;
            inc_id     <= 1'b1;
            cgram_mode <= 1'b0;
          end
          INS_HOME: begin
            ac         <= LINE1_BASE;
            cgram_mode <= 1'b0;
          end
          INS_ENTRY:   inc_id <= d_s[ENTRY_ID];
          INS_DISPLAY: {display_on, cursor_on, blink_on} <= d_s[2:0];
          INS_SHIFT:   if (!d_s[SHIFT_SC]) ac <= ac_next(ac, d_s[SHIFT_RL]);
          INS_FUNC:    two_line <= d_s[FUNC_N];
          INS_CGRAM:   cgram_mode <= 1'b1;
          INS_DDRAM: begin
            ac         <= d_s[6:0];
            cgram_mode <= 1'b0;
          end
          default: ;
        endcase
      end else if (rd_fall) begin
        ac <= ac_next(ac, inc_id);
      end
    end
  end

`ifdef LCD_DISPLAY_SHIFT_EN
  logic entry_s;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift   <= '0;
      entry_s <= 1'b0;
    end else if (wr_acc && rs_s) begin
      if (entry_s && !cgram_mode) shift <= shift_step(shift, inc_id);
    end else if (wr_acc) begin
      case (instr)
        INS_CLEAR, INS_HOME: shift <= '0;
        INS_ENTRY:           entry_s <= d_s[0];
        INS_SHIFT:           if (d_s[SHIFT_SC]) shift <= shift_step(shift, d_s[SHIFT_RL]);
        default: ;
      endcase
    end
  end
`else
  assign shift = '0;
`endif

  // Single DDRAM write port: clear fill and bus data writes never coincide
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = ddram_index(ac);
    mem_wdata = d_s;
    if (clr_we) begin
      mem_we    = 1'b1;
      mem_waddr = cnt[6:0];
      mem_wdata = CLEAR_CHAR;
    end else if (wr_acc && rs_s && !cgram_mode && ddram_valid(ac)) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) ddram[mem_waddr] <= mem_wdata;
  end

  assign bus_rd_data = ddram_valid(ac) ? ddram[ddram_index(ac)] : 8'h00;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lcd_d_oe  <= 1'b0;
      lcd_d_out <= '0;
    end else begin
      lcd_d_oe <= en_s & rw_s;
      if (en_s && rw_s) lcd_d_out <= rs_s ? bus_rd_data : {busy, ac};
    end
  end

  always_comb begin
    col_sum = {3'b000, rd_col} + {1'b0, shift};
    col_mod = (col_sum >= 7'(LINE_LEN)) ? col_sum - 7'(LINE_LEN) : col_sum;
    rd_idx  = rd_row ? col_mod + 7'(LINE_LEN) : col_mod;
  end

  // A write landing on the cell being read is forwarded so the readout never lags it
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                           rd_char <= '0;
    else if (!display_on)                   rd_char <= CLEAR_CHAR;
    else if (mem_we && mem_waddr == rd_idx) rd_char <= mem_wdata;
    else                                    rd_char <= ddram[rd_idx];
  end

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Bench for lcd_bus_responder: directed bring-up plus randomized bus traffic, checked
// against a linear-position model of the controller's DDRAM, address counter and flags.
`timescale 1ns/1ps
module tb_lcd_bus_responder;

  localparam int         BUSY = 200;
  localparam logic [7:0] CLR  = 8'h20;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       lcd_en = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
  logic [7:0] lcd_d = 8'h00;
  logic [7:0] lcd_d_out;
  logic       lcd_d_oe;
  logic       rd_row = 1'b0;
  logic [3:0] rd_col = 4'd0;
  logic [7:0] rd_char;
  logic       display_on, cursor_on, blink_on, two_line, busy, overrun;
  logic [6:0] ac;

  always #5 clock = ~clock;

  lcd_bus_responder #(.BUSY_CYCLES(BUSY), .CLEAR_CHAR(CLR)) dut (
    .clock(clock), .reset_n(reset_n),
    .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_d(lcd_d),
    .lcd_d_out(lcd_d_out), .lcd_d_oe(lcd_d_oe),
    .rd_row(rd_row), .rd_col(rd_col), .rd_char(rd_char),
    .display_on(display_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .two_line(two_line), .busy(busy), .ac(ac), .overrun(overrun)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the display as 80 linear cells, cursor as a position 0..79
  logic [7:0] m_mem [80];
  int         m_pos;
  bit         m_inc, m_disp, m_cur, m_blink, m_two;

  logic [7:0] rd_sample;
  logic       oe_high, oe_after;

  function automatic logic [6:0] pos_to_ac(input int p);
    return (p < 40) ? 7'(p) : 7'(64 + p - 40);
  endfunction

  function automatic int ac_to_pos(input logic [6:0] a);
    return a[6] ? 40 + int'(a[5:0]) : int'(a[5:0]);
  endfunction

  function automatic void m_step(input bit inc);
    m_pos = inc ? (m_pos + 1) % 80 : (m_pos + 79) % 80;
  endfunction

  task automatic bus_xfer(input logic rs, input logic rw, input logic [7:0] d);
    @(negedge clock);
    lcd_rs = rs; lcd_rw = rw; lcd_d = d; lcd_en = 1'b1;
    repeat (5) @(negedge clock);
    rd_sample = lcd_d_out;
    oe_high   = lcd_d_oe;
    @(negedge clock);
    lcd_en = 1'b0;
    repeat (6) @(negedge clock);
    oe_after = lcd_d_oe;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle busy=%b required 0", busy);
    end
  endtask

  task automatic wr_cmd(input logic [7:0] d);
    wait_idle();
    bus_xfer(1'b0, 1'b0, d);
    casez (d)
      8'b1???_????: m_pos = ac_to_pos(d[6:0]);
      8'b01??_????: ;
      8'b001?_????: m_two = d[3];
      8'b0001_????: if (!d[3]) m_step(d[2]);
      8'b0000_1???: {m_disp, m_cur, m_blink} = d[2:0];
      8'b0000_01??: m_inc = d[1];
      8'b0000_001?: m_pos = 0;
      8'b0000_0001: begin
        m_pos = 0;
        m_inc = 1'b1;
        for (int i = 0; i < 80; i++) m_mem[i] = CLR;
      end
      default: ;
    endcase
  endtask

  task automatic wr_data(input logic [7:0] d);
    wait_idle();
    bus_xfer(1'b1, 1'b0, d);
    m_mem[m_pos] = d;
    m_step(m_inc);
  endtask

  task automatic read_cell(input logic row, input logic [3:0] col, output logic [7:0] v);
    @(negedge clock);
    rd_row = row; rd_col = col;
    @(negedge clock);
    v = rd_char;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({display_on, cursor_on, blink_on, two_line, busy, overrun} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got %b required 000000",
               {display_on, cursor_on, blink_on, two_line, busy, overrun});
    end
    checks++;
    if (ac !== 7'h00) begin errors++; $display("FAIL reset_ac got %h required 00", ac); end
    checks++;
    if (lcd_d_oe !== 1'b0 || lcd_d_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_bus got oe=%b out=%h required 0/00", lcd_d_oe, lcd_d_out);
    end
    checks++;
    if (rd_char !== 8'h00) begin errors++; $display("FAIL reset_rd_char got %h required 00", rd_char); end
    @(negedge clock);
    reset_n = 1'b1;
    m_pos = 0; m_inc = 1'b1; m_disp = 1'b0; m_cur = 1'b0; m_blink = 1'b0; m_two = 1'b0;
  endtask

  task automatic test_init();
    int n, cnt;
    logic [7:0] v, e;
    wr_cmd(8'h38);
    wr_cmd(8'h0E);
    wait_idle();
    @(negedge clock);
    lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_d = 8'h01; lcd_en = 1'b1;
    repeat (6) @(negedge clock);
    lcd_en = 1'b0;
    n = 0;
    while (busy !== 1'b1 && n < 20) begin @(negedge clock); n++; end
    cnt = 0;
    while (busy === 1'b1 && cnt < 1000) begin @(negedge clock); cnt++; end
    checks++;
    if (cnt != 80) begin errors++; $display("FAIL clear_busy_len got %0d required 80", cnt); end
    m_pos = 0; m_inc = 1'b1;
    for (int i = 0; i < 80; i++) m_mem[i] = CLR;
    wr_cmd(8'h06);
    checks++;
    if ({two_line, display_on, cursor_on, blink_on} !== {m_two, m_disp, m_cur, m_blink}) begin
      errors++;
      $display("FAIL init_flags got %b required %b", {two_line, display_on, cursor_on, blink_on},
               {m_two, m_disp, m_cur, m_blink});
    end
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 16; c++) begin
        read_cell(r[0], c[3:0], v);
        e = m_mem[r * 40 + c];
        checks++;
        if (v !== e) begin errors++; $display("FAIL init_window r%0d c%0d got %h required %h", r, c, v, e); end
      end
  endtask

  task automatic test_data_write();
    logic [7:0] msg [4];
    logic [7:0] v;
    msg[0] = 8'h4E; msg[1] = 8'h53; msg[2] = 8'h3A; msg[3] = 8'h30;
    wr_cmd(8'h80);
    for (int i = 0; i < 4; i++) wr_data(msg[i]);
    for (int i = 0; i < 4; i++) begin
      read_cell(1'b0, i[3:0], v);
      checks++;
      if (v !== msg[i]) begin errors++; $display("FAIL row0 c%0d got %h required %h", i, v, msg[i]); end
    end
    checks++;
    if (ac !== pos_to_ac(m_pos)) begin errors++; $display("FAIL ac_after_ns got %h required %h", ac, pos_to_ac(m_pos)); end
  endtask

  task automatic test_line2();
    logic [7:0] v;
    wr_cmd(8'hC0);
    for (int i = 0; i < 16; i++) wr_data(8'(8'h41 + i));
    for (int i = 0; i < 16; i++) begin
      read_cell(1'b1, i[3:0], v);
      checks++;
      if (v !== 8'(8'h41 + i)) begin errors++; $display("FAIL row1 c%0d got %h required %h", i, v, 8'(8'h41 + i)); end
    end
    checks++;
    if (ac !== 7'h50) begin errors++; $display("FAIL ac_after_row1 got %h required 50", ac); end
    wr_cmd(8'h80);
    checks++;
    if (ac !== 7'h00) begin errors++; $display("FAIL ac_home_addr got %h required 00", ac); end
  endtask

  task automatic test_wrap();
    logic [7:0] x [3];
    logic [7:0] e, v;
    for (int i = 0; i < 3; i++) x[i] = 8'($urandom_range(8'h21, 8'h7E));
    wr_cmd(8'hA7); wr_data(x[0]);
    checks++;
    if (ac !== 7'h40) begin errors++; $display("FAIL wrap_27 got %h required 40", ac); end
    wr_cmd(8'hE7); wr_data(x[1]);
    checks++;
    if (ac !== 7'h00) begin errors++; $display("FAIL wrap_67 got %h required 00", ac); end
    wr_cmd(8'h04); wr_data(x[2]);
    checks++;
    if (ac !== 7'h67) begin errors++; $display("FAIL wrap_dec00 got %h required 67", ac); end
    wr_cmd(8'h06);
    for (int i = 0; i < 3; i++) begin
      wr_cmd(i == 0 ? 8'hA7 : (i == 1 ? 8'hE7 : 8'h80));
      wait_idle();
      e = m_mem[m_pos];
      bus_xfer(1'b1, 1'b1, 8'h00);
      m_step(m_inc);
      checks++;
      if (rd_sample !== e || e !== x[i] || oe_high !== 1'b1) begin
        errors++;
        $display("FAIL data_read%0d got %h oe=%b required %h oe=1", i, rd_sample, oe_high, x[i]);
      end
      checks++;
      if (ac !== pos_to_ac(m_pos)) begin errors++; $display("FAIL read_adv%0d got %h required %h", i, ac, pos_to_ac(m_pos)); end
    end
    read_cell(1'b0, 4'd0, v);
    checks++;
    if (v !== x[2]) begin errors++; $display("FAIL wrap_cell0 got %h required %h", v, x[2]); end
  endtask

  task automatic test_overrun();
    logic [7:0] v, d;
    wr_cmd(8'h80);
    wait_idle();
    d = ~m_mem[0];
    bus_xfer(1'b0, 1'b0, 8'h0C);
    m_disp = 1'b1; m_cur = 1'b0; m_blink = 1'b0;
    bus_xfer(1'b1, 1'b0, d);
    checks++;
    if (overrun !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL overrun got ovr=%b busy=%b required 1/1", overrun, busy);
    end
    read_cell(1'b0, 4'd0, v);
    checks++;
    if (v !== m_mem[0]) begin errors++; $display("FAIL dropped_write got %h required %h", v, m_mem[0]); end
    checks++;
    if (ac !== 7'h00 || cursor_on !== m_cur || display_on !== m_disp) begin
      errors++;
      $display("FAIL overrun_state got ac=%h cur=%b disp=%b required 00/%b/%b", ac, cursor_on, display_on, m_cur, m_disp);
    end
  endtask

  task automatic test_random();
    logic [7:0] v, e;
    int op, p;
    for (int k = 0; k < 40; k++) begin
      op = $urandom_range(0, 4);
      case (op)
        0: begin p = $urandom_range(0, 79); wr_cmd(8'h80 | {1'b0, pos_to_ac(p)}); end
        1: wr_data(8'($urandom_range(0, 255)));
        2: begin
          wait_idle();
          e = m_mem[m_pos];
          bus_xfer(1'b1, 1'b1, 8'h00);
          m_step(m_inc);
          checks++;
          if (rd_sample !== e) begin errors++; $display("FAIL rand_read%0d got %h required %h", k, rd_sample, e); end
        end
        3: wr_cmd(8'h04 | 8'($urandom_range(0, 1) << 1));
        default: wr_cmd(8'h10 | 8'($urandom_range(0, 1) << 2));
      endcase
    end
    wait_idle();
    checks++;
    if (ac !== pos_to_ac(m_pos)) begin errors++; $display("FAIL rand_ac got %h required %h", ac, pos_to_ac(m_pos)); end
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 16; c++) begin
        read_cell(r[0], c[3:0], v);
        e = m_mem[r * 40 + c];
        checks++;
        if (v !== e) begin errors++; $display("FAIL rand_window r%0d c%0d got %h required %h", r, c, v, e); end
      end
    wr_cmd(8'h08);
    read_cell(1'b1, 4'd3, v);
    checks++;
    if (v !== CLR) begin errors++; $display("FAIL display_off got %h required %h", v, CLR); end
    wr_cmd(8'h0C);
  endtask

  task automatic test_status_clear_reset();
    logic [7:0] v;
    wr_cmd(8'h01);
    bus_xfer(1'b0, 1'b1, 8'h00);
    checks++;
    if (rd_sample !== {1'b1, pos_to_ac(m_pos)} || oe_high !== 1'b1 || oe_after !== 1'b0) begin
      errors++;
      $display("FAIL status_in_clear got %h oe=%b/%b required %h oe=1/0", rd_sample, oe_high, oe_after,
               {1'b1, pos_to_ac(m_pos)});
    end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL still_clearing got busy=%b required 1", busy); end
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || ac !== 7'h00 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL abort_clear got busy=%b ac=%h ovr=%b required 0/00/0", busy, ac, overrun);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    read_cell(1'b0, 4'd5, v);
    checks++;
    if (v !== CLR) begin errors++; $display("FAIL post_reset_readout got %h required %h", v, CLR); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_data_write();
    test_line2();
    test_wrap();
    test_overrun();
    test_random();
    test_status_clear_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
